// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode/writeback/resolve bundle for the hazard controller
interface pipeline_hazard_ctrl_if;
    logic        decode_v;
    logic [4:0]  decode_rs1;
    logic        decode_rs1_used;
    logic [4:0]  decode_rs2;
    logic        decode_rs2_used;
    logic [4:0]  decode_rd;
    logic        decode_rd_w_v;
    logic        decode_pc_w_v;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic        resolve_v;
    logic        resolve_taken;
    logic        stall_o;
    logic        bubble_o;
    logic        flush_o;
    logic        err_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output decode_v, decode_rs1, decode_rs1_used, decode_rs2, decode_rs2_used,
               decode_rd, decode_rd_w_v, decode_pc_w_v, wb_v, wb_rd,
               resolve_v, resolve_taken,
        input  stall_o, bubble_o, flush_o, err_o, stall_cnt_o
    );

    modport slave (
        input  decode_v, decode_rs1, decode_rs1_used, decode_rs2, decode_rs2_used,
               decode_rd, decode_rd_w_v, decode_pc_w_v, wb_v, wb_rd,
               resolve_v, resolve_taken,
        output stall_o, bubble_o, flush_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - scoreboard RAW/WAW interlock plus control-hazard stall/flush sequencer
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {RUN, CTRL_WAIT, FLUSH} state_t;

    state_t              state;
    logic                flush_cnt;
    logic                err_q;
    logic [15:0]         stall_cnt_q;
    logic [CNT_W-1:0]    cnt [0:31];

    logic [CNT_W-1:0]    rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
    logic                hazard, stall, issue;
    logic                inc_en, wb_hit, dec_en, wb_err, same_reg;

    assign rs1_cnt = cnt[hz.decode_rs1];
    assign rs2_cnt = cnt[hz.decode_rs2];
    assign rd_cnt  = cnt[hz.decode_rd];
    assign wb_cnt  = cnt[hz.wb_rd];

    // x0 is excluded explicitly so its (always zero) entry can never create a hazard
    always_comb begin
        hazard = hz.decode_v &&
                 ((hz.decode_rs1_used && hz.decode_rs1 != 5'd0 && rs1_cnt != '0) ||
                  (hz.decode_rs2_used && hz.decode_rs2 != 5'd0 && rs2_cnt != '0) ||
                  (hz.decode_rd_w_v   && hz.decode_rd  != 5'd0 && (&rd_cnt)));
        stall  = (state == RUN && hazard) ||
                 (state == CTRL_WAIT && hz.decode_v) ||
                 (state == FLUSH);
        issue  = hz.decode_v && !stall && state == RUN;
    end

    always_comb begin
        inc_en   = issue && hz.decode_rd_w_v && hz.decode_rd != 5'd0;
        wb_hit   = hz.wb_v && hz.wb_rd != 5'd0;
        dec_en   = wb_hit && wb_cnt != '0;
        wb_err   = wb_hit && wb_cnt == '0;
        same_reg = hz.decode_rd == hz.wb_rd;
    end

    assign hz.stall_o     = stall;
    assign hz.bubble_o    = !issue;
    assign hz.flush_o     = (state == FLUSH);
    assign hz.err_o       = err_q;
    assign hz.stall_cnt_o = stall_cnt_q;

    // A retiring write and a new write to the same register cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (inc_en && !(dec_en && same_reg)) begin
                cnt[hz.decode_rd] <= rd_cnt + CNT_W'(1);
            end
            if (dec_en && !(inc_en && same_reg)) begin
                cnt[hz.wb_rd] <= wb_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            flush_cnt   <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (wb_err) begin
                err_q <= 1'b1;
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            case (state)
                RUN: begin
                    if (issue && hz.decode_pc_w_v) begin
                        state <= CTRL_WAIT;
                    end
                end
                CTRL_WAIT: begin
                    if (hz.resolve_v) begin
                        state     <= hz.resolve_taken ? FLUSH : RUN;
                        flush_cnt <= 1'b0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scenarios plus randomized run against a behavioural scoreboard model
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    int total = 0;
    int bad   = 0;

    // behavioural model: pending write counts per register and a sequencer mode
    int pend [32];
    int m_mode;        // 0 = running, 1 = waiting on control, 2 = flushing
    int m_flush_left;
    bit m_err;
    int m_scnt;
    bit e_stall, e_bubble, e_flush, e_issue;

    task automatic idle();
        hz.decode_v = 0; hz.decode_rs1 = 0; hz.decode_rs1_used = 0;
        hz.decode_rs2 = 0; hz.decode_rs2_used = 0; hz.decode_rd = 0;
        hz.decode_rd_w_v = 0; hz.decode_pc_w_v = 0;
        hz.wb_v = 0; hz.wb_rd = 0; hz.resolve_v = 0; hz.resolve_taken = 0;
    endtask

    task automatic set_dec(input bit v, input logic [4:0] rs1, input bit u1,
                           input logic [4:0] rs2, input bit u2,
                           input logic [4:0] rd, input bit w, input bit pc);
        hz.decode_v = v; hz.decode_rs1 = rs1; hz.decode_rs1_used = u1;
        hz.decode_rs2 = rs2; hz.decode_rs2_used = u2;
        hz.decode_rd = rd; hz.decode_rd_w_v = w; hz.decode_pc_w_v = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_mode = 0; m_flush_left = 0; m_err = 0; m_scnt = 0;
    endtask

    task automatic model_eval();
        bit haz;
        haz = hz.decode_v &&
              ((hz.decode_rs1_used && pend[hz.decode_rs1] > 0) ||
               (hz.decode_rs2_used && pend[hz.decode_rs2] > 0) ||
               (hz.decode_rd_w_v && hz.decode_rd != 0 && pend[hz.decode_rd] == MAXC));
        if (m_mode == 0)      e_stall = haz;
        else if (m_mode == 1) e_stall = hz.decode_v;
        else                  e_stall = 1;
        e_issue  = hz.decode_v && !e_stall && m_mode == 0;
        e_bubble = !e_issue;
        e_flush  = (m_mode == 2);
    endtask

    task automatic model_advance();
        if (rst) begin
            model_reset();
        end else begin
            if (e_stall && m_scnt < 65535) m_scnt++;
            if (hz.wb_v && hz.wb_rd != 0) begin
                if (pend[hz.wb_rd] > 0) pend[hz.wb_rd]--;
                else m_err = 1;
            end
            if (e_issue && hz.decode_rd_w_v && hz.decode_rd != 0) pend[hz.decode_rd]++;
            case (m_mode)
                0: if (e_issue && hz.decode_pc_w_v) m_mode = 1;
                1: if (hz.resolve_v) begin
                       if (hz.resolve_taken) begin m_mode = 2; m_flush_left = 2; end
                       else m_mode = 0;
                   end
                default: begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_mode = 0;
                end
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1; idle(); tick(); tick(); rst = 0;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b010) begin bad++;
            $display("FAIL reset_sbf got=%b want=010", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        total++; if (hz.err_o !== 1'b0) begin bad++;
            $display("FAIL reset_err got=%b want=0", hz.err_o); end
        total++; if (hz.stall_cnt_o !== 16'd0) begin bad++;
            $display("FAIL reset_stall_cnt got=%0d want=0", hz.stall_cnt_o); end
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 5, 1, 0);
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b000) begin bad++;
            $display("FAIL raw_issue_x5 got=%b want=000", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0);
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b110) begin bad++;
            $display("FAIL raw_stall got=%b want=110", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        hz.wb_v = 1; hz.wb_rd = 5;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b110) begin bad++;
            $display("FAIL raw_no_bypass got=%b want=110", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        hz.wb_v = 0;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b000) begin bad++;
            $display("FAIL raw_release got=%b want=000", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        idle();
    endtask

    task automatic test_x0();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_dec(1, 0, 1, 0, 1, 0, 1, 0);
            @(negedge clk);
            total++; if ({hz.stall_o, hz.bubble_o} !== 2'b00) begin bad++;
                $display("FAIL x0_no_stall[%0d] got=%b want=00", i, {hz.stall_o, hz.bubble_o}); end
            tick();
        end
        idle();
        hz.wb_v = 1; hz.wb_rd = 0;
        tick();
        hz.wb_v = 0;
        @(negedge clk);
        total++; if (hz.err_o !== 1'b0) begin bad++;
            $display("FAIL x0_wb_no_err got=%b want=0", hz.err_o); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < MAXC; i++) begin
            set_dec(1, 0, 0, 0, 0, 7, 1, 0);
            @(negedge clk);
            total++; if ({hz.stall_o, hz.bubble_o} !== 2'b00) begin bad++;
                $display("FAIL sat_issue[%0d] got=%b want=00", i, {hz.stall_o, hz.bubble_o}); end
            tick();
        end
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o} !== 2'b11) begin bad++;
            $display("FAIL sat_fourth_stalls got=%b want=11", {hz.stall_o, hz.bubble_o}); end
        tick();
        hz.wb_v = 1; hz.wb_rd = 7;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o} !== 2'b11) begin bad++;
            $display("FAIL sat_wb_same_cycle got=%b want=11", {hz.stall_o, hz.bubble_o}); end
        tick();
        hz.wb_v = 0;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o} !== 2'b00) begin bad++;
            $display("FAIL sat_release got=%b want=00", {hz.stall_o, hz.bubble_o}); end
        tick();
        idle();
    endtask

    task automatic test_taken_branch();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b000) begin bad++;
            $display("FAIL tk_issue got=%b want=000", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        set_dec(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin hz.resolve_v = 1; hz.resolve_taken = 1; end
            @(negedge clk);
            total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b110) begin bad++;
                $display("FAIL tk_wait[%0d] got=%b want=110", c, {hz.stall_o, hz.bubble_o, hz.flush_o}); end
            tick();
        end
        hz.resolve_v = 0; hz.resolve_taken = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b111) begin bad++;
                $display("FAIL tk_flush[%0d] got=%b want=111", c, {hz.stall_o, hz.bubble_o, hz.flush_o}); end
            tick();
        end
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b000) begin bad++;
            $display("FAIL tk_back_to_run got=%b want=000", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        total++; if (hz.stall_cnt_o !== 16'd5) begin bad++;
            $display("FAIL tk_stall_cnt got=%0d want=5", hz.stall_cnt_o); end
        tick();
        idle();
    endtask

    task automatic test_not_taken_simul();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        set_dec(1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b000) begin bad++;
            $display("FAIL nt_branch_issue got=%b want=000", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        set_dec(1, 0, 0, 0, 0, 0, 0, 0);
        hz.resolve_v = 1; hz.resolve_taken = 0;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b110) begin bad++;
            $display("FAIL nt_wait got=%b want=110", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        hz.resolve_v = 0;
        set_dec(1, 0, 0, 0, 0, 3, 1, 0);
        hz.wb_v = 1; hz.wb_rd = 3;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b000) begin bad++;
            $display("FAIL nt_run_incdec got=%b want=000", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        hz.wb_v = 0;
        set_dec(1, 3, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o} !== 2'b11) begin bad++;
            $display("FAIL nt_cnt3_nonzero got=%b want=11", {hz.stall_o, hz.bubble_o}); end
        tick();
        hz.wb_v = 1; hz.wb_rd = 3;
        tick();
        hz.wb_v = 0;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o} !== 2'b00) begin bad++;
            $display("FAIL nt_cnt3_was_one got=%b want=00", {hz.stall_o, hz.bubble_o}); end
        total++; if (hz.err_o !== 1'b0) begin bad++;
            $display("FAIL nt_no_err got=%b want=0", hz.err_o); end
        tick();
        idle();
    endtask

    task automatic test_err_reset();
        do_reset();
        hz.wb_v = 1; hz.wb_rd = 9;
        @(negedge clk);
        total++; if (hz.err_o !== 1'b0) begin bad++;
            $display("FAIL err_not_yet got=%b want=0", hz.err_o); end
        tick();
        hz.wb_v = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (hz.err_o !== 1'b1) begin bad++;
                $display("FAIL err_sticky[%0d] got=%b want=1", i, hz.err_o); end
            tick();
        end
        set_dec(1, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        hz.resolve_v = 1; hz.resolve_taken = 1;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b010) begin bad++;
            $display("FAIL err_wait_idle got=%b want=010", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        tick();
        idle();
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o} !== 3'b111) begin bad++;
            $display("FAIL err_in_flush got=%b want=111", {hz.stall_o, hz.bubble_o, hz.flush_o}); end
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        total++; if ({hz.stall_o, hz.bubble_o, hz.flush_o, hz.err_o} !== 4'b0100) begin bad++;
            $display("FAIL err_after_rst got=%b want=0100", {hz.stall_o, hz.bubble_o, hz.flush_o, hz.err_o}); end
        total++; if (hz.stall_cnt_o !== 16'd0) begin bad++;
            $display("FAIL err_after_rst_cnt got=%0d want=0", hz.stall_cnt_o); end
        tick();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst = ($urandom_range(63) == 0);
            set_dec($urandom_range(3) != 0,
                    5'($urandom_range(7)), 1'($urandom_range(1)),
                    5'($urandom_range(7)), 1'($urandom_range(1)),
                    5'($urandom_range(7)), 1'($urandom_range(1)),
                    $urandom_range(7) == 0);
            r = $urandom_range(7);
            hz.wb_rd = 5'(r);
            hz.wb_v = (pend[r] > 0) ? 1'($urandom_range(1)) : ($urandom_range(39) == 0);
            hz.resolve_v = ($urandom_range(2) == 0);
            hz.resolve_taken = 1'($urandom_range(1));
            @(negedge clk);
            model_eval();
            total++; if (hz.stall_o !== e_stall) begin bad++;
                $display("FAIL rnd_stall cyc=%0d got=%b want=%b", cyc, hz.stall_o, e_stall); end
            total++; if (hz.bubble_o !== e_bubble) begin bad++;
                $display("FAIL rnd_bubble cyc=%0d got=%b want=%b", cyc, hz.bubble_o, e_bubble); end
            total++; if (hz.flush_o !== e_flush) begin bad++;
                $display("FAIL rnd_flush cyc=%0d got=%b want=%b", cyc, hz.flush_o, e_flush); end
            total++; if (hz.err_o !== m_err) begin bad++;
                $display("FAIL rnd_err cyc=%0d got=%b want=%b", cyc, hz.err_o, m_err); end
            total++; if (hz.stall_cnt_o !== 16'(m_scnt)) begin bad++;
                $display("FAIL rnd_stall_cnt cyc=%0d got=%0d want=%0d", cyc, hz.stall_cnt_o, m_scnt); end
            model_advance();
            tick();
        end
        rst = 0;
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_raw();
        test_x0();
        test_saturation();
        test_taken_branch();
        test_not_taken_simul();
        test_err_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
